// File: rtl/signed_mult_arbiter.sv
// Round-robin arbiter that feeds N_REQ requesters into one shared signed AW x BW multiplier.
// Two pipeline stages (operands, product) with valid/ready backpressure and a requester tag.
module signed_mult_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 16,
    parameter int unsigned BW    = 8,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*AW-1:0]   a_bus,
    input  logic [N_REQ*BW-1:0]   b_bus,
    output logic [N_REQ-1:0]      gnt,
    output logic [AW+BW-1:0]      p,
    output logic [IDW-1:0]        p_id,
    output logic                  p_valid,
    input  logic                  p_ready
);

    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [AW-1:0]     s1_a_q, s1_a_d;
    logic [BW-1:0]     s1_b_q, s1_b_d;
    logic [IDW-1:0]    s1_id_q, s1_id_d;
    logic [AW+BW-1:0]  p_q, p_d;
    logic [IDW-1:0]    p_id_q, p_id_d;
    logic              p_valid_q, p_valid_d;

    logic              adv1, adv2;
    logic              found;
    logic [IDW-1:0]    gnt_idx;
    logic [IDW:0]      scan_idx;
    logic [AW-1:0]     sel_a;
    logic [BW-1:0]     sel_b;
    logic signed [AW+BW-1:0] prod;

    assign adv2 = !p_valid_q || p_ready;
    assign adv1 = !s1_valid_q || adv2;

    // Scan from ptr upwards with wrap; first requester found wins.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(N_REQ)) begin
                scan_idx = scan_idx - (IDW+1)'(N_REQ);
            end
            if (!found && req[scan_idx[IDW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (found && adv1 && !rst) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a = a_bus[i*AW +: AW];
                sel_b = b_bus[i*BW +: BW];
            end
        end
    end

    // Operands are widened to the full product width first so nothing is truncated.
    assign prod = (AW+BW)'($signed(s1_a_q)) * (AW+BW)'($signed(s1_b_q));

    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        p_d        = p_q;
        p_id_d     = p_id_q;
        p_valid_d  = p_valid_q;

        if (|gnt) begin
            ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end

        if (adv1) begin
            s1_valid_d = |gnt;
            if (|gnt) begin
                s1_a_d  = sel_a;
                s1_b_d  = sel_b;
                s1_id_d = gnt_idx;
            end
        end

        if (adv2) begin
            p_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                p_d    = prod;
                p_id_d = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            p_q        <= '0;
            p_id_q     <= '0;
            p_valid_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            p_q        <= p_d;
            p_id_q     <= p_id_d;
            p_valid_q  <= p_valid_d;
        end
    end

    assign p       = p_q;
    assign p_id    = p_id_q;
    assign p_valid = p_valid_q;

endmodule
